// File: rtl/sprite_motion_if.sv
// Scan-position, mode and button inputs plus sprite position/direction outputs
// shared between the VGA timing side and the sprite motion controller.
interface sprite_motion_if;
  logic [9:0] pixelx_i;
  logic [9:0] pixely_i;
  logic       auto_mode_i;
  logic       pause_i;
  logic       btn_up_i;
  logic       btn_down_i;
  logic       btn_left_i;
  logic       btn_right_i;
  logic [9:0] posx_o;
  logic [9:0] posy_o;
  logic       dir_x_o;
  logic       dir_y_o;
  logic       bounce_o;

  modport master (
    output pixelx_i, pixely_i, auto_mode_i, pause_i,
           btn_up_i, btn_down_i, btn_left_i, btn_right_i,
    input  posx_o, posy_o, dir_x_o, dir_y_o, bounce_o
  );

  modport slave (
    input  pixelx_i, pixely_i, auto_mode_i, pause_i,
           btn_up_i, btn_down_i, btn_left_i, btn_right_i,
    output posx_o, posy_o, dir_x_o, dir_y_o, bounce_o
  );
endinterface

// File: rtl/sprite_motion_ctrl.sv
// Sprite top-left position generator: moves once every FRAME_DIV frames during
// vertical blanking, either bouncing autonomously or following the buttons.
module sprite_motion_ctrl #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int SPRITE_W  = 64,
  parameter int SPRITE_H  = 64,
  parameter int STEP      = 2,
  parameter int FRAME_DIV = 2,
  parameter int INIT_X    = 288,
  parameter int INIT_Y    = 208
) (
  input  logic            clk,
  input  logic            rst,
  sprite_motion_if.slave  bus
);

  //  state      | meaning
  //  S_WAIT     | idle until the frame divider fires (and not paused)
  //  S_MOVE_X   | compute and register the new x position/direction
  //  S_MOVE_Y   | compute and register the new y position/direction
  localparam logic [1:0] S_WAIT   = 2'd0;
  localparam logic [1:0] S_MOVE_X = 2'd1;
  localparam logic [1:0] S_MOVE_Y = 2'd2;

  localparam logic [10:0] MAX_X   = 11'(H_ACTIVE - SPRITE_W);
  localparam logic [10:0] MAX_Y   = 11'(V_ACTIVE - SPRITE_H);
  localparam logic [10:0] STEP11  = 11'(STEP);
  localparam logic [9:0]  V_ACT10 = 10'(V_ACTIVE);
  localparam logic [7:0]  DIV_TC  = 8'(FRAME_DIV - 1);

  logic [1:0] state_q, state_d;
  logic       fe_cond_q;
  logic [7:0] cnt_q, cnt_d;
  logic [9:0] posx_q, posx_d, posy_q, posy_d;
  logic       dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic       bounce_q, bounce_d;
  logic [3:0] btn_meta_q, btn_sync_q;  // {up, down, left, right}

  logic fe_cond, frame_evt, upd;

  assign fe_cond   = (bus.pixelx_i == 10'd0) && (bus.pixely_i == V_ACT10);
  assign frame_evt = fe_cond & ~fe_cond_q;
  assign upd       = frame_evt && (cnt_q == DIV_TC);

  // Returns {bounce, dir, pos}. inc moves toward lim, dec toward 0.
  function automatic logic [11:0] step_axis(
    input logic [9:0]  pos,
    input logic        dir,
    input logic        auto_m,
    input logic        inc,
    input logic        dec,
    input logic [10:0] lim
  );
    logic [10:0] p;
    logic [10:0] sum;
    logic [10:0] diff;
    logic [11:0] res;
    p    = {1'b0, pos};
    sum  = p + STEP11;
    diff = p - STEP11;
    res  = {1'b0, dir, pos};
    if (auto_m) begin
      if (dir) begin
        if (sum >= lim) res = {1'b1, 1'b0, lim[9:0]};
        else            res = {1'b0, 1'b1, sum[9:0]};
      end else begin
        if (p <= STEP11) res = {1'b1, 1'b1, 10'd0};
        else             res = {1'b0, 1'b0, diff[9:0]};
      end
    end else if (inc && !dec) begin
      res = {1'b0, dir, (sum > lim) ? lim[9:0] : sum[9:0]};
    end else if (dec && !inc) begin
      res = {1'b0, dir, (p <= STEP11) ? 10'd0 : diff[9:0]};
    end
    return res;
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    posx_d   = posx_q;
    posy_d   = posy_q;
    dir_x_d  = dir_x_q;
    dir_y_d  = dir_y_q;
    bounce_d = 1'b0;

    if (frame_evt) cnt_d = upd ? 8'd0 : cnt_q + 8'd1;

    case (state_q)
      S_WAIT: begin
        if (upd && !bus.pause_i) state_d = S_MOVE_X;
      end
      S_MOVE_X: begin
        {bounce_d, dir_x_d, posx_d} = step_axis(posx_q, dir_x_q, bus.auto_mode_i,
                                                btn_sync_q[0], btn_sync_q[1], MAX_X);
        state_d = S_MOVE_Y;
      end
      S_MOVE_Y: begin
        {bounce_d, dir_y_d, posy_d} = step_axis(posy_q, dir_y_q, bus.auto_mode_i,
                                                btn_sync_q[2], btn_sync_q[3], MAX_Y);
        state_d = S_WAIT;
      end
      default: state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_WAIT;
      fe_cond_q  <= 1'b0;
      cnt_q      <= 8'd0;
      posx_q     <= 10'(INIT_X);
      posy_q     <= 10'(INIT_Y);
      dir_x_q    <= 1'b1;
      dir_y_q    <= 1'b1;
      bounce_q   <= 1'b0;
      btn_meta_q <= 4'd0;
      btn_sync_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      fe_cond_q  <= fe_cond;
      cnt_q      <= cnt_d;
      posx_q     <= posx_d;
      posy_q     <= posy_d;
      dir_x_q    <= dir_x_d;
      dir_y_q    <= dir_y_d;
      bounce_q   <= bounce_d;
      btn_meta_q <= {bus.btn_up_i, bus.btn_down_i, bus.btn_left_i, bus.btn_right_i};
      btn_sync_q <= btn_meta_q;
    end
  end

  assign bus.posx_o   = posx_q;
  assign bus.posy_o   = posy_q;
  assign bus.dir_x_o  = dir_x_q;
  assign bus.dir_y_o  = dir_y_q;
  assign bus.bounce_o = bounce_q;

endmodule
